// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and the future transmitter.
package uart_pkg;

  localparam int OVS_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator: one-cycle tick every CLK_HZ/(BAUD*OVS) clocks.
module uart_baud_tick #(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  output logic tick
);

  localparam int DIV_RAW  = CLK_HZ / (BAUD * OVS);
  localparam int TICK_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // clr realigns the tick phase to the start-bit edge so mid-bit sampling is deterministic.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)              cnt <= '0;
    else if (clr || tick)   cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling, valid/ready output and error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115200,
  parameter int OVS    = OVS_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int OW = (OVS > 2) ? $clog2(OVS) : 1;
  localparam logic [OW-1:0] HALF = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] FULL = OW'(OVS - 1);

  logic          sync1, rx_s, rx_prev;
  logic          fall, clr, tick, deliver, err_wait;
  rx_state_t     state;
  logic [OW-1:0] ovs_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (clr),
    .tick  (tick)
  );

  // Synchronizer resets to the idle-high level so release never fakes a start edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= ser_rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  assign fall    = rx_prev & ~rx_s;
  assign clr     = (state == ST_IDLE) && fall;
  assign deliver = (state == ST_STOP) && !err_wait && tick && (ovs_cnt == FULL) && rx_s;

  // NOTE: sequential state uses <= only, so every branch sees the pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      ovs_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      err_wait  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: if (fall) begin
          state   <= ST_START;
          ovs_cnt <= '0;
        end
        ST_START: if (tick) begin
          if (ovs_cnt == HALF) begin
            ovs_cnt <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            ovs_cnt <= ovs_cnt + 1'b1;
          end
        end
        ST_DATA: if (tick) begin
          if (ovs_cnt == FULL) begin
            ovs_cnt        <= '0;
            shreg[bit_cnt] <= rx_s;
            if (bit_cnt == 3'd7) state   <= ST_STOP;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end else begin
            ovs_cnt <= ovs_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // After a framing error, hold here until the line returns to idle.
          if (err_wait) begin
            if (rx_s) begin
              err_wait <= 1'b0;
              state    <= ST_IDLE;
            end
          end else if (tick) begin
            if (ovs_cnt == FULL) begin
              ovs_cnt <= '0;
              if (rx_s) begin
                state <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                err_wait  <= 1'b1;
              end
            end else begin
              ovs_cnt <= ovs_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A handshake frees the holding register first, so a same-cycle delivery is never an overrun.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (rx_valid && rx_ready) begin
      if (deliver) rx_data  <= shreg;
      else         rx_valid <= 1'b0;
    end else if (deliver) begin
      if (rx_valid) begin
        overrun <= 1'b1;
      end else begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, corner-case sequences, random frames.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_HZ   = 27_000_000;
  localparam int BAUD     = 115200;
  localparam int OVS      = 16;
  localparam int BIT_CLKS = (CLK_HZ / (BAUD * OVS)) * OVS;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ser_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  always #5 CLK = ~CLK;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ser_rx    (ser_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge away from the active edge.
  logic [7:0] hs_q[$];
  int valid_cycles = 0;
  int fe_cycles = 0;
  int fe_run = 0;
  int fe_max_run = 0;

  always @(negedge CLK) begin
    if (rx_valid) valid_cycles++;
    if (rx_valid && rx_ready) hs_q.push_back(rx_data);
    if (frame_err) begin
      fe_cycles++;
      fe_run++;
      if (fe_run > fe_max_run) fe_max_run = fe_run;
    end else begin
      fe_run = 0;
    end
  end

  function automatic logic [7:0] last_hs();
    return (hs_q.size() > 0) ? hs_q[hs_q.size()-1] : 8'h00;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    ser_rx = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      step(BIT_CLKS);
    end
    ser_rx = stop_ok;
    step(BIT_CLKS);
    ser_rx = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},   32'(rx_data),   32'h00);
    check({tag, "_rx_valid"},  32'(rx_valid),  32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_overrun"},   32'(overrun),   32'h0);
    check({tag, "_state"},     32'(dut.state), 32'(ST_IDLE));
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(3);
    RESET = 1'b0;
    step(2);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       exp_byte;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n0, v0, f0;
    logic [7:0] exp_q[$];
    int exp_fe;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h12, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0};

    step(3);
    check_reset_outputs("reset");
    RESET = 1'b0;
    step(5);

    // Table-driven frames with the consumer always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n0 = hs_q.size();
      v0 = valid_cycles;
      f0 = fe_cycles;
      send_byte(vecs[i].data, vecs[i].stop_ok);
      step(16);
      check($sformatf("vec%0d_bytes", i),  32'(hs_q.size() - n0),    32'(vecs[i].exp_byte));
      check($sformatf("vec%0d_vcyc", i),   32'(valid_cycles - v0),   32'(vecs[i].exp_byte));
      check($sformatf("vec%0d_fe", i),     32'(fe_cycles - f0),      32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_valid", i),  32'(rx_valid),            32'h0);
      if (vecs[i].exp_byte)
        check($sformatf("vec%0d_data", i), 32'(last_hs()), 32'(vecs[i].data));
    end
    check("fe_pulse_width", 32'(fe_max_run), 32'd1);

    // Back-to-back frames with no consumer: first byte kept, second dropped.
    rx_ready = 1'b0;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h81, 1'b1);
    step(16);
    check("ovr_valid",   32'(rx_valid), 32'h1);
    check("ovr_data",    32'(rx_data),  32'h3C);
    check("ovr_overrun", 32'(overrun),  32'h1);
    rx_ready = 1'b1;
    step(1);
    check("ovr_hs_data", 32'(last_hs()), 32'h3C);
    check("ovr_cleared", 32'(rx_valid),  32'h0);
    step(4);
    check("ovr_sticky",  32'(overrun),   32'h1);
    do_reset();
    check("ovr_reset",   32'(overrun),   32'h0);

    // Short low glitch on an idle line is rejected.
    v0 = valid_cycles;
    f0 = fe_cycles;
    ser_rx = 1'b0;
    step(3);
    ser_rx = 1'b1;
    step(200);
    check("glitch_valid", 32'(valid_cycles - v0), 32'd0);
    check("glitch_fe",    32'(fe_cycles - f0),    32'd0);
    check("glitch_state", 32'(dut.state),         32'(ST_IDLE));

    // Reset in the middle of data bit 4 of 0xFF.
    n0 = hs_q.size();
    v0 = valid_cycles;
    ser_rx = 1'b0;
    step(BIT_CLKS);
    ser_rx = 1'b1;
    step(BIT_CLKS * 4 + BIT_CLKS / 2);
    RESET = 1'b1;
    step(2);
    check_reset_outputs("midreset");
    RESET = 1'b0;
    step(BIT_CLKS * 6);
    check("midreset_novalid", 32'(valid_cycles - v0), 32'd0);
    check("midreset_state",   32'(dut.state),         32'(ST_IDLE));
    send_byte(8'h0F, 1'b1);
    step(16);
    check("after_reset_bytes", 32'(hs_q.size() - n0), 32'd1);
    check("after_reset_data",  32'(last_hs()),        32'h0F);

    // Handshake in the same cycle as delivery of a new byte.
    rx_ready = 1'b0;
    send_byte(8'h44, 1'b1);
    step(16);
    check("sim_hold_valid", 32'(rx_valid), 32'h1);
    check("sim_hold_data",  32'(rx_data),  32'h44);
    fork
      send_byte(8'h77, 1'b1);
      begin
        repeat (2130) @(posedge CLK);
        #1 rx_ready = 1'b1;
        @(posedge CLK);
        #1 rx_ready = 1'b0;
      end
    join
    step(4);
    check("sim_data",    32'(rx_data),   32'h77);
    check("sim_valid",   32'(rx_valid),  32'h1);
    check("sim_overrun", 32'(overrun),   32'h0);
    check("sim_hs_old",  32'(last_hs()), 32'h44);
    rx_ready = 1'b1;
    step(1);
    check("sim_hs_new",  32'(last_hs()), 32'h77);
    check("sim_cleared", 32'(rx_valid),  32'h0);

    // Random frames against a frame-level model: good stop bit -> byte, bad -> one error pulse.
    n0 = hs_q.size();
    f0 = fe_cycles;
    exp_fe = 0;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      logic ok;
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      if (ok) exp_q.push_back(b);
      else    exp_fe++;
      send_byte(b, ok);
      step($urandom_range(16, 200));
    end
    check("rand_count", 32'(hs_q.size() - n0), 32'(exp_q.size()));
    check("rand_fe",    32'(fe_cycles - f0),   32'(exp_fe));
    for (int i = 0; i < exp_q.size() && (n0 + i) < hs_q.size(); i++)
      check($sformatf("rand_byte%0d", i), 32'(hs_q[n0 + i]), 32'(exp_q[i]));
    check("rand_overrun", 32'(overrun), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27_000_000, the CLK frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, the serial bit rate.
REQ-003 SHALL have parameter OVS, default 16, the oversampling ticks per bit.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port ser_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data, output, 8 bits: received byte.
REQ-008 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_ready, input, 1 bit: consumer accepts the byte when rx_valid & rx_ready.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a byte has a bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag set when a byte is lost; cleared only by RESET.

Function
REQ-012 SHALL use the frame format 8N1, LSB first.
REQ-013 SHALL pass ser_rx through a 2-FF synchronizer before any use, giving 2 cycles of input latency.
REQ-014 SHALL generate a one-cycle tick every TICK_DIV = CLK_HZ/(BAUD*OVS) clocks (integer division, minimum 1), with a free-running counter that wraps to 0 on the tick.
REQ-015 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-016 SHALL move IDLE->START on a synchronized falling edge (1->0), and reset the OVS tick counter at that point.
REQ-017 SHALL, in START at tick OVS/2-1, resample the line: low -> DATA with the bit counter at 0; high -> IDLE (glitch rejected; no output).
REQ-018 SHALL, in DATA, sample the line every OVS ticks at mid-bit, shift it into bit[bitcnt], and move to STOP after bitcnt=7.
REQ-019 SHALL, in STOP, sample at mid-bit: high -> deliver the byte; low -> pulse frame_err for 1 cycle, discard the byte, and return to IDLE only after the line is seen high.
REQ-020 SHALL, on delivery, load rx_data and set rx_valid in the cycle after the stop sample, with the FSM returning to IDLE in that same cycle.
REQ-021 SHALL hold rx_valid and rx_data stable until a handshake; rx_valid SHALL clear in the cycle after rx_valid & rx_ready.
REQ-022 SHALL handle delivery while rx_valid=1 with no handshake that cycle by keeping the old rx_data, dropping the new byte, and setting overrun.
REQ-023 SHALL give precedence to the handshake when a handshake and a new delivery occur in the same cycle: rx_data takes the new byte, rx_valid stays 1, and overrun is not set.
REQ-024 SHALL not affect the FSM through rx_ready; reception SHALL continue regardless of backpressure.

Reset
REQ-025 SHALL, while RESET=1, force state=IDLE, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, the synchronizer flops=1 and all counters=0.
REQ-026 SHALL, when RESET asserts mid-frame, abort the frame, deliver no partial byte, and after release wait in IDLE for a new falling edge.

Structure
REQ-027 SHALL take the FSM state enum (rx_state_t) and the OVS default from package uart_pkg, shared with the future transmitter.
REQ-028 SHALL place the tick generator in sub-module uart_baud_tick (params CLK_HZ, BAUD, OVS; ports CLK, RESET, clr, tick).
REQ-029 SHALL have a total RTL size of about 150-250 lines.

Verification (CLK_HZ=27e6, BAUD=115200, OVS=16 -> TICK_DIV=14, bit=224 clk)
REQ-030 SHALL cover: send 0xA5 with rx_ready=1 -> rx_valid pulses 1 cycle, rx_data=8'hA5, frame_err=0.
REQ-031 SHALL cover: send 0x3C then 0x81 back-to-back with rx_ready=0 -> rx_data stays 8'h3C, overrun=1; then rx_ready=1 -> rx_valid clears.
REQ-032 SHALL cover: a 3-clock low glitch on an idle line -> no rx_valid, state back at IDLE, no frame_err.
REQ-033 SHALL cover: send 0x55 with the stop bit held low -> frame_err one-cycle pulse, rx_valid stays 0; next valid 0x12 is received correctly.
REQ-034 SHALL cover: RESET asserted at data bit 4 of 0xFF -> all outputs at reset values; next 0x0F is received as 8'h0F.
REQ-035 SHALL cover: handshake in the same cycle as delivery of 0x77 -> rx_data=8'h77, rx_valid=1, overrun=0.
